// File: rtl/crossbar_seq.sv
//------------------------------------------------------------------------------
// Module   : crossbar_seq
// Purpose  : Sequences FORM/WRITE/MAC commands into timed setup/pulse/hold
//            drive of the crossbar lines and returns MAC results.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module crossbar_seq #(
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 4,
    parameter int FORM_CYC  = 16,
    parameter int HOLD_CYC  = 2,
    parameter int CNT_W     = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [2:0] cmd_row,
    input  logic [2:0] cmd_col,
    input  logic [7:0] cmd_data,
    output logic [7:0] bitline,
    output logic [7:0] wordline,
    output logic [7:0] selectline,
    output logic [7:0] x,
    output logic       wenable,
    output logic       form,
    output logic       mac,
    input  logic [7:0] xb_out,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic       busy
);

    localparam logic [1:0] c_OP_NOP   = 2'b00;
    localparam logic [1:0] c_OP_FORM  = 2'b01;
    localparam logic [1:0] c_OP_WRITE = 2'b10;
    localparam logic [1:0] c_OP_MAC   = 2'b11;

    localparam logic [CNT_W-1:0] c_SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] c_FORM_LD  = CNT_W'(FORM_CYC - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_PULSE = 3'd2,
        S_HOLD  = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        op_q, op_d;
    logic [2:0]        row_q, row_d;
    logic [2:0]        col_q, col_d;
    logic [7:0]        data_q, data_d;

    logic [7:0]        bitline_q, bitline_d;
    logic [7:0]        wordline_q, wordline_d;
    logic [7:0]        selectline_q, selectline_d;
    logic [7:0]        x_q, x_d;
    logic              wenable_q, wenable_d;
    logic              form_q, form_d;
    logic              mac_q, mac_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [7:0]        rsp_data_q, rsp_data_d;
    logic              cmd_ready_q, cmd_ready_d;
    logic              busy_q, busy_d;

    logic              drive_d;
    logic              pulse_d;
    logic              hold_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        row_d      = row_q;
        col_d      = col_q;
        data_d     = data_q;
        rsp_data_d = rsp_data_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d       = cmd_op;
                    row_d      = cmd_row;
                    col_d      = cmd_col;
                    data_d     = cmd_data;
                    rsp_data_d = 8'h00;
                    if (cmd_op == c_OP_NOP) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_SETUP;
                        cnt_d   = c_SETUP_LD;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = (op_q == c_OP_FORM) ? c_FORM_LD : c_PULSE_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = c_HOLD_LD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d    = S_RESP;
                    rsp_data_d = (op_q == c_OP_MAC) ? xb_out : 8'h00;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are decoded from the next state so they register in step with it.
        drive_d = (state_d == S_SETUP) || (state_d == S_PULSE) || (state_d == S_HOLD);
        pulse_d = (state_d == S_PULSE);
        hold_d  = (state_d == S_HOLD);

        bitline_d    = 8'h00;
        wordline_d   = 8'h00;
        selectline_d = 8'h00;
        x_d          = 8'h00;
        if (drive_d) begin
            if (op_d == c_OP_MAC) begin
                wordline_d   = data_d;
                selectline_d = 8'hFF;
            end else begin
                wordline_d   = 8'h01 << row_d;
                selectline_d = 8'h01 << row_d;
                bitline_d    = 8'h01 << col_d;
                x_d          = (op_d == c_OP_WRITE) ? data_d : 8'h00;
            end
        end

        wenable_d   = pulse_d && (op_d == c_OP_WRITE);
        form_d      = pulse_d && (op_d == c_OP_FORM);
        mac_d       = (pulse_d || hold_d) && (op_d == c_OP_MAC);
        rsp_valid_d = (state_d == S_RESP);
        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            op_q         <= c_OP_NOP;
            row_q        <= 3'd0;
            col_q        <= 3'd0;
            data_q       <= 8'h00;
            bitline_q    <= 8'h00;
            wordline_q   <= 8'h00;
            selectline_q <= 8'h00;
            x_q          <= 8'h00;
            wenable_q    <= 1'b0;
            form_q       <= 1'b0;
            mac_q        <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_data_q   <= 8'h00;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            row_q        <= row_d;
            col_q        <= col_d;
            data_q       <= data_d;
            bitline_q    <= bitline_d;
            wordline_q   <= wordline_d;
            selectline_q <= selectline_d;
            x_q          <= x_d;
            wenable_q    <= wenable_d;
            form_q       <= form_d;
            mac_q        <= mac_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
        end
    end

    assign bitline    = bitline_q;
    assign wordline   = wordline_q;
    assign selectline = selectline_q;
    assign x          = x_q;
    assign wenable    = wenable_q;
    assign form       = form_q;
    assign mac        = mac_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign cmd_ready  = cmd_ready_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_crossbar_seq.sv
//------------------------------------------------------------------------------
// Module   : tb_crossbar_seq
// Purpose  : Self-checking bench for crossbar_seq against a cycle-indexed model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_crossbar_seq;

    localparam int SETUP_CYC = 2;
    localparam int PULSE_CYC = 4;
    localparam int FORM_CYC  = 16;
    localparam int HOLD_CYC  = 2;

    localparam logic [1:0] c_NOP   = 2'b00;
    localparam logic [1:0] c_FORM  = 2'b01;
    localparam logic [1:0] c_WRITE = 2'b10;
    localparam logic [1:0] c_MAC   = 2'b11;

    logic       clk;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [2:0] cmd_row;
    logic [2:0] cmd_col;
    logic [7:0] cmd_data;
    logic [7:0] bitline;
    logic [7:0] wordline;
    logic [7:0] selectline;
    logic [7:0] x;
    logic       wenable;
    logic       form;
    logic       mac;
    logic [7:0] xb_out;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic       busy;

    int vectors = 0;
    int miscompares = 0;

    crossbar_seq #(
        .SETUP_CYC (SETUP_CYC),
        .PULSE_CYC (PULSE_CYC),
        .FORM_CYC  (FORM_CYC),
        .HOLD_CYC  (HOLD_CYC),
        .CNT_W     (8)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_row    (cmd_row),
        .cmd_col    (cmd_col),
        .cmd_data   (cmd_data),
        .bitline    (bitline),
        .wordline   (wordline),
        .selectline (selectline),
        .x          (x),
        .wenable    (wenable),
        .form       (form),
        .mac        (mac),
        .xb_out     (xb_out),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {cmd_ready, busy, rsp_valid, wenable, form, mac, bitline, wordline, selectline, x}
    logic [37:0] obs;
    assign obs = {cmd_ready, busy, rsp_valid, wenable, form, mac,
                  bitline, wordline, selectline, x};

    localparam logic [37:0] c_IDLE_VEC = {1'b1, 1'b0, 1'b0, 3'b000, 32'h0};
    localparam logic [37:0] c_RESP_VEC = {1'b0, 1'b1, 1'b1, 3'b000, 32'h0};

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int total_cycles(input logic [1:0] op);
        if (op == c_NOP)  return 0;
        if (op == c_FORM) return SETUP_CYC + FORM_CYC + HOLD_CYC;
        return SETUP_CYC + PULSE_CYC + HOLD_CYC;
    endfunction

    // Expected outputs k cycles after the accept edge (k = 1 is the first cycle).
    function automatic logic [37:0] exp_vec(input logic [1:0] op, input logic [2:0] row,
                                            input logic [2:0] col, input logic [7:0] data,
                                            input int k);
        int p_len;
        logic in_pulse, in_hold;
        logic [7:0] wl, sl, bl, xx;
        logic we, fm, mc;
        p_len = (op == c_FORM) ? FORM_CYC : PULSE_CYC;
        if (k > total_cycles(op)) return c_RESP_VEC;
        in_pulse = (k > SETUP_CYC) && (k <= SETUP_CYC + p_len);
        in_hold  = (k > SETUP_CYC + p_len);
        if (op == c_MAC) begin
            wl = data; sl = 8'hFF; bl = 8'h00; xx = 8'h00;
        end else begin
            wl = 8'(1 << row); sl = wl; bl = 8'(1 << col);
            xx = (op == c_WRITE) ? data : 8'h00;
        end
        we = (op == c_WRITE) && in_pulse;
        fm = (op == c_FORM) && in_pulse;
        mc = (op == c_MAC) && (in_pulse || in_hold);
        return {1'b0, 1'b1, 1'b0, we, fm, mc, bl, wl, sl, xx};
    endfunction

    task automatic scramble_cmd();
        cmd_valid = 1'($urandom);
        cmd_op    = 2'($urandom);
        cmd_row   = 3'($urandom);
        cmd_col   = 3'($urandom);
        cmd_data  = 8'($urandom);
    endtask

    // Entered in an IDLE cycle; returns in the IDLE cycle after the handshake.
    // xb_out is xb_a before cycle sw and xb_b from cycle sw on.
    task automatic do_cmd(input logic [1:0] op, input logic [2:0] row, input logic [2:0] col,
                          input logic [7:0] data, input int stall,
                          input logic [7:0] xb_a, input logic [7:0] xb_b, input int sw);
        int t;
        int waited;
        logic [7:0] exp_rsp;
        t = total_cycles(op);
        exp_rsp = (op == c_MAC) ? ((t < sw) ? xb_a : xb_b) : 8'h00;
        check_eq("idle_before", {26'h0, obs}, {26'h0, c_IDLE_VEC});
        cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_col = col; cmd_data = data;
        xb_out = xb_a;
        tick();
        for (int k = 1; k <= t; k++) begin
            check_eq("drive", {26'h0, obs}, {26'h0, exp_vec(op, row, col, data, k)});
            scramble_cmd();
            rsp_ready = 1'($urandom);
            xb_out = (k < sw) ? xb_a : xb_b;
            tick();
        end
        waited = 0;
        forever begin
            check_eq("resp", {26'h0, obs}, {26'h0, c_RESP_VEC});
            check_eq("rsp_data", {56'h0, rsp_data}, {56'h0, exp_rsp});
            scramble_cmd();
            cmd_valid = 1'b1;
            xb_out = 8'($urandom);
            rsp_ready = (waited >= stall);
            tick();
            if (rsp_ready) break;
            waited++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check_eq("idle_after", {26'h0, obs}, {26'h0, c_IDLE_VEC});
    endtask

    task automatic reset_mid_form();
        check_eq("rst_pre_idle", {26'h0, obs}, {26'h0, c_IDLE_VEC});
        cmd_valid = 1'b1; cmd_op = c_FORM; cmd_row = 3'd2; cmd_col = 3'd6; cmd_data = 8'h00;
        tick();
        for (int k = 1; k <= SETUP_CYC + 3; k++) begin
            check_eq("rst_pre_drive", {26'h0, obs}, {26'h0, exp_vec(c_FORM, 3'd2, 3'd6, 8'h00, k)});
            cmd_valid = 1'b0;
            tick();
        end
        rst = 1'b1;
        rsp_ready = 1'b1;
        tick();
        check_eq("rst_cycle1", {26'h0, obs}, {26'h0, c_IDLE_VEC});
        tick();
        check_eq("rst_cycle2", {26'h0, obs}, {26'h0, c_IDLE_VEC});
        rst = 1'b0;
        for (int k = 0; k < FORM_CYC + 8; k++) begin
            tick();
            check_eq("rst_no_resp", {26'h0, obs}, {26'h0, c_IDLE_VEC});
        end
        rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: bench did not reach summary");
        $fatal(1);
    end

    initial begin
        logic [1:0] op;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_row = 3'd0; cmd_col = 3'd0;
        cmd_data = 8'h00; xb_out = 8'h00; rsp_ready = 1'b0;
        tick(); tick();
        check_eq("reset_state", {26'h0, obs}, {26'h0, c_IDLE_VEC});
        check_eq("reset_rsp_data", {56'h0, rsp_data}, 64'h0);
        rst = 1'b0;
        tick();
        check_eq("post_reset_idle", {26'h0, obs}, {26'h0, c_IDLE_VEC});

        // Directed cases from the plan
        do_cmd(c_WRITE, 3'd3, 3'd5, 8'hA5, 0, 8'h00, 8'h00, 0);
        do_cmd(c_FORM, 3'd0, 3'd7, 8'h00, 0, 8'h00, 8'h00, 0);
        do_cmd(c_MAC, 3'd0, 3'd0, 8'h3C, 0, 8'h11, 8'h5A, 7);
        do_cmd(c_MAC, 3'd1, 3'd4, 8'hC3, 10, 8'h77, 8'h99, 8);
        do_cmd(c_WRITE, 3'd7, 3'd0, 8'hFF, 10, 8'h00, 8'h00, 0);
        do_cmd(c_NOP, 3'd0, 3'd0, 8'h00, 0, 8'h00, 8'h00, 0);
        do_cmd(c_MAC, 3'd0, 3'd0, 8'h81, 0, 8'h12, 8'h34, 9);
        do_cmd(c_MAC, 3'd0, 3'd0, 8'h7E, 0, 8'hAB, 8'hCD, 1);

        reset_mid_form();

        // Randomized traffic with occasional idle gaps
        for (int n = 0; n < 60; n++) begin
            op = 2'($urandom);
            do_cmd(op, 3'($urandom), 3'($urandom), 8'($urandom),
                   int'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
                   int'($urandom_range(1, 21)));
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    check_eq("gap_idle", {26'h0, obs}, {26'h0, c_IDLE_VEC});
                end
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
